// File: rtl/typedefs_pkg.sv
// Shared types, flash patterns and sizing helpers for the LED sequencer.
package typedefs_pkg;

  // Raw state encoding width shared by sequencer-style blocks.
  typedef logic [2:0] state_t;

  typedef enum logic [2:0] {
    StIdle,
    StShowOn,
    StShowGap,
    StFlashOn,
    StFlashOff
  } led_seq_state_t;

  // Flash patterns; users slice off the low DATA_WIDTH bits (LSB = bit 0).
  localparam logic [31:0] LED_ALL_ON   = 32'hFFFF_FFFF;
  localparam logic [31:0] LED_DEFEAT_A = 32'hAAAA_AAAA;  // ...1010, odd blinks
  localparam logic [31:0] LED_DEFEAT_B = 32'h5555_5555;  // ...0101, even blinks

  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/led_sequencer_if.sv
// Request/status bundle between the game controller and the LED sequencer.
interface led_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 4
);
  logic                  show_req;
  logic [DATA_WIDTH-1:0] show_item;
  logic                  speed;
  logic                  flash_req;
  logic                  flash_win;
  logic [DATA_WIDTH-1:0] leds;
  logic                  busy;
  logic                  show_done;
  logic                  flash_done;

  modport master (
    output show_req, show_item, speed, flash_req, flash_win,
    input  leds, busy, show_done, flash_done
  );

  modport slave (
    input  show_req, show_item, speed, flash_req, flash_win,
    output leds, busy, show_done, flash_done
  );
endinterface

// File: rtl/tick_timer.sv
// Loadable down-counter; expire_o marks the last cycle of a loaded duration.
module tick_timer #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             expire_o
);
  logic [Width-1:0] count_q, count_d;

  // Load wins over decrement; counter parks at zero when idle.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A duration of N spans N cycles, the last one seeing count_q == 1.
  assign expire_o = (count_q == Width'(1));
endmodule

// File: rtl/led_sequencer.sv
// Drives the colour LEDs: timed item display and end-of-game flashes.
module led_sequencer
  import typedefs_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned SLOW_TICKS = 8,
  parameter int unsigned FAST_TICKS = 4,
  parameter int unsigned GAP_TICKS  = 2,
  parameter int unsigned BLINKS     = 3
) (
  input logic            clk,
  input logic            rst,
  led_sequencer_if.slave bus
);
  localparam int unsigned TickW  = $clog2(max3(SLOW_TICKS, FAST_TICKS, GAP_TICKS) + 1);
  localparam int unsigned BlinkW = $clog2(BLINKS + 1);

  if (DATA_WIDTH == 0 || SLOW_TICKS == 0 || FAST_TICKS == 0 || GAP_TICKS == 0 ||
      BLINKS == 0 || DATA_WIDTH > 32) begin : g_bad_param
    $error("led_sequencer: parameters must be nonzero and DATA_WIDTH <= 32");
  end

  led_seq_state_t        state_q, state_d;
  logic [DATA_WIDTH-1:0] item_q, item_d;
  logic [DATA_WIDTH-1:0] leds_q, leds_d;
  logic [BlinkW-1:0]     blink_q, blink_d;
  logic                  win_q, win_d;
  logic                  show_done_q, show_done_d;
  logic                  flash_done_q, flash_done_d;
  logic                  load;
  logic [TickW-1:0]      load_val;
  logic                  expire;

  tick_timer #(
    .Width (TickW)
  ) u_tick_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (load),
    .load_val_i (load_val),
    .expire_o   (expire)
  );

  // Next state, latches, timer loads, done pulses and next LED value.
  always_comb begin
    state_d      = state_q;
    item_d       = item_q;
    win_d        = win_q;
    blink_d      = blink_q;
    load         = 1'b0;
    load_val     = '0;
    show_done_d  = 1'b0;
    flash_done_d = 1'b0;

    unique case (state_q)
      StIdle, StShowOn, StShowGap: begin
        if (bus.flash_req) begin
          // Flash beats a show, both from idle and mid-show (show aborts silently).
          state_d  = StFlashOn;
          win_d    = bus.flash_win;
          blink_d  = BlinkW'(1);
          load     = 1'b1;
          load_val = TickW'(FAST_TICKS);
        end else if (state_q == StIdle) begin
          if (bus.show_req) begin
            // Speed is consumed here via the load, so later changes cannot matter.
            state_d  = StShowOn;
            item_d   = bus.show_item;
            load     = 1'b1;
            load_val = bus.speed ? TickW'(FAST_TICKS) : TickW'(SLOW_TICKS);
          end
        end else if (expire) begin
          if (state_q == StShowOn) begin
            state_d  = StShowGap;
            load     = 1'b1;
            load_val = TickW'(GAP_TICKS);
          end else begin
            state_d     = StIdle;
            show_done_d = 1'b1;
          end
        end
      end
      StFlashOn: begin
        if (expire) begin
          state_d  = StFlashOff;
          load     = 1'b1;
          load_val = TickW'(FAST_TICKS);
        end
      end
      StFlashOff: begin
        if (expire) begin
          if (blink_q == BlinkW'(BLINKS)) begin
            state_d      = StIdle;
            flash_done_d = 1'b1;
          end else begin
            state_d  = StFlashOn;
            blink_d  = blink_q + 1'b1;
            load     = 1'b1;
            load_val = TickW'(FAST_TICKS);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // LEDs are registered, so derive them from the state being entered.
    leds_d = '0;
    if (state_d == StShowOn) begin
      leds_d = item_d;
    end else if (state_d == StFlashOn) begin
      if (win_d) begin
        leds_d = LED_ALL_ON[DATA_WIDTH-1:0];
      end else if (blink_d[0]) begin
        leds_d = LED_DEFEAT_A[DATA_WIDTH-1:0];
      end else begin
        leds_d = LED_DEFEAT_B[DATA_WIDTH-1:0];
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      item_q       <= '0;
      win_q        <= 1'b0;
      blink_q      <= '0;
      leds_q       <= '0;
      show_done_q  <= 1'b0;
      flash_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      item_q       <= item_d;
      win_q        <= win_d;
      blink_q      <= blink_d;
      leds_q       <= leds_d;
      show_done_q  <= show_done_d;
      flash_done_q <= flash_done_d;
    end
  end

  assign bus.leds       = leds_q;
  assign bus.busy       = (state_q != StIdle);
  assign bus.show_done  = show_done_q;
  assign bus.flash_done = flash_done_q;
endmodule
